// File: rtl/fwd_scoreboard.sv
// Hazard scoreboard and operand forwarding for the multi-lane SPU issue path.
// Tracks in-flight destinations per lane, raises one bundle stall and emits writeback strobes.
module fwd_scoreboard #(
    parameter int LANES  = 2,
    parameter int DEPTH  = 7,
    parameter int SRCS   = 3,
    parameter int REG_AW = 7,
    parameter int DATA_W = 128,
    parameter int LAT_W  = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [LANES-1:0]               issue_valid,
    input  logic [LANES-1:0]               issue_reg_write,
    input  logic [LANES*REG_AW-1:0]        issue_rt_addr,
    input  logic [LANES*LAT_W-1:0]         issue_lat,
    input  logic [LANES-1:0]               kill_mask,
    input  logic [LANES*SRCS-1:0]          src_used,
    input  logic [LANES*SRCS*REG_AW-1:0]   src_addr,
    input  logic [LANES*SRCS*DATA_W-1:0]   src_rf_data,
    input  logic [LANES*DEPTH*DATA_W-1:0]  stage_data,
    output logic                           stall,
    output logic [LANES*SRCS*DATA_W-1:0]   src_data,
    output logic [LANES*SRCS-1:0]          src_fwd_hit,
    output logic [LANES-1:0]               wb_valid,
    output logic [LANES*REG_AW-1:0]        wb_addr,
    output logic [LANES*DATA_W-1:0]        wb_data,
    output logic [15:0]                    stall_count
);

    logic [DEPTH-1:0]  v_q    [LANES];
    logic [REG_AW-1:0] addr_q [LANES][DEPTH];
    logic [LAT_W-1:0]  lat_q  [LANES][DEPTH];

    logic [LANES-1:0] issue_wr;
    logic             hazard;

    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
        if (lat == '0)
            return LAT_W'(1);
        if (int'(lat) > DEPTH)
            return LAT_W'(DEPTH);
        return lat;
    endfunction

    assign issue_wr = issue_valid & issue_reg_write & ~kill_mask;

    // Youngest match wins: scan oldest-to-youngest, lane 0 first, so later hits overwrite.
    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    always_comb begin : lookup_p
        logic [REG_AW-1:0] a;
        logic              match;
        logic              ready;
        logic              intra;
        int                sel_l;
        int                sel_k;
        int                idx;
        hazard      = 1'b0;
        src_data    = src_rf_data;
        src_fwd_hit = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < SRCS; s++) begin
                idx   = l * SRCS + s;
                a     = src_addr[idx*REG_AW +: REG_AW];
                match = 1'b0;
                ready = 1'b0;
                intra = 1'b0;
                sel_l = 0;
                sel_k = 0;
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    for (int m = 0; m < LANES; m++) begin
                        if (v_q[m][k] && addr_q[m][k] == a) begin
                            match = 1'b1;
                            ready = (k + 1 >= int'(lat_q[m][k]));
                            sel_l = m;
                            sel_k = k;
                        end
                    end
                end
                for (int i = 0; i < l; i++) begin
                    if (issue_wr[i] && issue_rt_addr[i*REG_AW +: REG_AW] == a)
                        intra = 1'b1;
                end
                if (src_used[idx]) begin
                    if (match && ready) begin
                        src_data[idx*DATA_W +: DATA_W] =
                            stage_data[(sel_l*DEPTH+sel_k)*DATA_W +: DATA_W];
                        src_fwd_hit[idx] = 1'b1;
                    end
                    if (issue_valid[l] && !kill_mask[l] && (intra || (match && !ready)))
                        hazard = 1'b1;
                end
            end
        end
    end

    // Held low while in reset so the bundle presented at deassertion is not blocked.
    assign stall = hazard & reset;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int l = 0; l < LANES; l++)
                v_q[l] <= '0;
            stall_count <= '0;
        end else begin
            for (int l = 0; l < LANES; l++)
                v_q[l] <= {v_q[l][DEPTH-2:0], issue_wr[l] & ~stall};
            if (stall && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end

    // NOTE: address/latency payload is left unreset; it is only ever observed behind its valid bit.
    always_ff @(posedge clk) begin
        for (int l = 0; l < LANES; l++) begin
            addr_q[l][0] <= issue_rt_addr[l*REG_AW +: REG_AW];
            lat_q[l][0]  <= clamp_lat(issue_lat[l*LAT_W +: LAT_W]);
            for (int k = 1; k < DEPTH; k++) begin
                addr_q[l][k] <= addr_q[l][k-1];
                lat_q[l][k]  <= lat_q[l][k-1];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_wb
        assign wb_valid[l]                    = v_q[l][DEPTH-1];
        assign wb_addr[l*REG_AW +: REG_AW]    = addr_q[l][DEPTH-1];
        assign wb_data[l*DATA_W +: DATA_W]    = stage_data[(l*DEPTH+DEPTH-1)*DATA_W +: DATA_W];
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: bundle vector table, multi-cycle sequences
// and a writeback scoreboard fed by the issuing code.
module tb_fwd_scoreboard;

    localparam int LANES  = 2;
    localparam int DEPTH  = 7;
    localparam int SRCS   = 3;
    localparam int REG_AW = 7;
    localparam int DATA_W = 128;
    localparam int LAT_W  = 3;

    logic                           clk = 1'b0;
    logic                           rst_n = 1'b0;
    logic [LANES-1:0]               issue_valid;
    logic [LANES-1:0]               issue_reg_write;
    logic [LANES*REG_AW-1:0]        issue_rt_addr;
    logic [LANES*LAT_W-1:0]         issue_lat;
    logic [LANES-1:0]               kill_mask;
    logic [LANES*SRCS-1:0]          src_used;
    logic [LANES*SRCS*REG_AW-1:0]   src_addr;
    logic [LANES*SRCS*DATA_W-1:0]   src_rf_data;
    logic [LANES*DEPTH*DATA_W-1:0]  stage_data;
    logic                           stall;
    logic [LANES*SRCS*DATA_W-1:0]   src_data;
    logic [LANES*SRCS-1:0]          src_fwd_hit;
    logic [LANES-1:0]               wb_valid;
    logic [LANES*REG_AW-1:0]        wb_addr;
    logic [LANES*DATA_W-1:0]        wb_data;
    logic [15:0]                    stall_count;

    fwd_scoreboard #(
        .LANES(LANES), .DEPTH(DEPTH), .SRCS(SRCS),
        .REG_AW(REG_AW), .DATA_W(DATA_W), .LAT_W(LAT_W)
    ) dut (
        .clk(clk), .reset(rst_n),
        .issue_valid(issue_valid), .issue_reg_write(issue_reg_write),
        .issue_rt_addr(issue_rt_addr), .issue_lat(issue_lat), .kill_mask(kill_mask),
        .src_used(src_used), .src_addr(src_addr), .src_rf_data(src_rf_data),
        .stage_data(stage_data), .stall(stall), .src_data(src_data),
        .src_fwd_hit(src_fwd_hit), .wb_valid(wb_valid), .wb_addr(wb_addr),
        .wb_data(wb_data), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc++;

    typedef struct {
        int                lane;
        logic [REG_AW-1:0] addr;
        int                cycle;
    } wb_exp_t;
    wb_exp_t wbq[$];

    typedef struct {
        logic              v0;
        logic              w0;
        logic [REG_AW-1:0] rt0;
        logic              v1;
        logic [1:0]        kill;
        logic              used1;
        logic [REG_AW-1:0] a1;
        logic              exp_stall;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [DATA_W-1:0] sd(input int l, input int k);
        return {4{32'hD000_0000 + 32'(l * 256 + k)}};
    endfunction

    function automatic logic [DATA_W-1:0] rf(input int l, input int s);
        return {4{32'hF000_0000 + 32'(l * 16 + s)}};
    endfunction

    function automatic logic [DATA_W-1:0] got_data(input int l, input int s);
        return src_data[(l*SRCS+s)*DATA_W +: DATA_W];
    endfunction

    function automatic logic got_hit(input int l, input int s);
        return src_fwd_hit[l*SRCS+s];
    endfunction

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_inputs();
        issue_valid     = '0;
        issue_reg_write = '0;
        issue_rt_addr   = '0;
        issue_lat       = '0;
        kill_mask       = '0;
        src_used        = '0;
        src_addr        = '0;
    endtask

    task automatic set_issue(input int l, input logic [REG_AW-1:0] rt, input logic [LAT_W-1:0] lat);
        issue_valid[l]                  = 1'b1;
        issue_reg_write[l]              = 1'b1;
        issue_rt_addr[l*REG_AW +: REG_AW] = rt;
        issue_lat[l*LAT_W +: LAT_W]     = lat;
    endtask

    task automatic set_src(input int l, input int s, input logic [REG_AW-1:0] a);
        issue_valid[l]                             = 1'b1;
        src_used[l*SRCS+s]                         = 1'b1;
        src_addr[(l*SRCS+s)*REG_AW +: REG_AW]      = a;
    endtask

    task automatic push_wb(input int l, input logic [REG_AW-1:0] a);
        wb_exp_t e;
        e.lane  = l;
        e.addr  = a;
        e.cycle = cyc + DEPTH;
        wbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Writeback monitor: each strobe must match the oldest outstanding accepted write.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int l = 0; l < LANES; l++) begin
                if (wb_valid[l]) begin
                    if (wbq.size() == 0) begin
                        check("wb_unexpected", 1'b1, 1'b0);
                    end else begin
                        wb_exp_t e;
                        e = wbq.pop_front();
                        check("wb_lane", DATA_W'(l), DATA_W'(e.lane));
                        check("wb_addr", DATA_W'(wb_addr[l*REG_AW +: REG_AW]), DATA_W'(e.addr));
                        check("wb_cycle", DATA_W'(cyc), DATA_W'(e.cycle));
                        check("wb_data", wb_data[l*DATA_W +: DATA_W], sd(l, DEPTH-1));
                    end
                end
            end
        end
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 7'd9, 1'b1, 2'b00, 1'b1, 7'd9,  1'b1};
        vecs[1] = '{1'b1, 1'b1, 7'd9, 1'b1, 2'b01, 1'b1, 7'd9,  1'b0};
        vecs[2] = '{1'b1, 1'b1, 7'd9, 1'b1, 2'b10, 1'b1, 7'd9,  1'b0};
        vecs[3] = '{1'b1, 1'b0, 7'd9, 1'b1, 2'b00, 1'b1, 7'd9,  1'b0};
        vecs[4] = '{1'b1, 1'b1, 7'd9, 1'b1, 2'b00, 1'b0, 7'd9,  1'b0};
        vecs[5] = '{1'b1, 1'b1, 7'd9, 1'b1, 2'b00, 1'b1, 7'd10, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 7'd9, 1'b0, 2'b00, 1'b1, 7'd9,  1'b0};
        vecs[7] = '{1'b0, 1'b1, 7'd9, 1'b1, 2'b00, 1'b1, 7'd9,  1'b0};

        for (int l = 0; l < LANES; l++) begin
            for (int k = 0; k < DEPTH; k++)
                stage_data[(l*DEPTH+k)*DATA_W +: DATA_W] = sd(l, k);
            for (int s = 0; s < SRCS; s++)
                src_rf_data[(l*SRCS+s)*DATA_W +: DATA_W] = rf(l, s);
        end
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_stall", stall, 1'b0);
        check("rst_wb_valid", wb_valid, '0);
        check("rst_stall_count", stall_count, '0);
        check("rst_fwd_hit", src_fwd_hit, '0);
        step();

        // Single-bundle vectors with an empty pipe; inputs are withdrawn before each edge.
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            if (vecs[i].v0) begin
                issue_valid[0]              = 1'b1;
                issue_reg_write[0]          = vecs[i].w0;
                issue_rt_addr[0 +: REG_AW]  = vecs[i].rt0;
                issue_lat[0 +: LAT_W]       = 3'd1;
            end
            issue_valid[1] = vecs[i].v1;
            kill_mask      = vecs[i].kill;
            src_used[SRCS] = vecs[i].used1;
            src_addr[SRCS*REG_AW +: REG_AW] = vecs[i].a1;
            #1;
            check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
            check($sformatf("vec%0d_hit", i), got_hit(1, 0), 1'b0);
            check($sformatf("vec%0d_data", i), got_data(1, 0), rf(1, 0));
            clear_inputs();
            step();
        end
        check("vec_no_count", stall_count, '0);

        // Latency 4 producer, consumer one cycle later: three stall cycles, then forward from k=3.
        clear_inputs();
        set_issue(0, 7'd5, 3'd4);
        push_wb(0, 7'd5);
        #1 check("lat_issue_stall", stall, 1'b0);
        step();
        clear_inputs();
        set_src(1, 0, 7'd5);
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("lat_stall_k%0d", i), stall, 1'b1);
            step();
        end
        #1;
        check("lat_release_stall", stall, 1'b0);
        check("lat_fwd_hit", got_hit(1, 0), 1'b1);
        check("lat_fwd_data", got_data(1, 0), sd(0, 3));
        check("lat_stall_count", stall_count, 16'd3);
        clear_inputs();
        step();

        // Latency 0 behaves as 1: ready at k=0.
        set_issue(0, 7'd7, 3'd0);
        push_wb(0, 7'd7);
        step();
        clear_inputs();
        set_src(0, 1, 7'd7);
        #1;
        check("lat0_stall", stall, 1'b0);
        check("lat0_hit", got_hit(0, 1), 1'b1);
        check("lat0_data", got_data(0, 1), sd(0, 0));
        clear_inputs();
        step();

        // Two writers of r12 at k=5 and k=2: the younger one forwards.
        set_issue(0, 7'd12, 3'd1);
        push_wb(0, 7'd12);
        step();
        clear_inputs();
        repeat (2) step();
        set_issue(0, 7'd12, 3'd1);
        push_wb(0, 7'd12);
        step();
        clear_inputs();
        repeat (2) step();
        set_src(1, 2, 7'd12);
        #1;
        check("youngest_stall", stall, 1'b0);
        check("youngest_hit", got_hit(1, 2), 1'b1);
        check("youngest_data", got_data(1, 2), sd(0, 2));
        clear_inputs();
        step();

        // Equal age on both lanes: lane 1 wins.
        set_issue(0, 7'd20, 3'd1);
        set_issue(1, 7'd20, 3'd1);
        push_wb(0, 7'd20);
        push_wb(1, 7'd20);
        #1 check("eqk_issue_stall", stall, 1'b0);
        step();
        clear_inputs();
        set_src(0, 2, 7'd20);
        #1;
        check("eqk_hit", got_hit(0, 2), 1'b1);
        check("eqk_data", got_data(0, 2), sd(1, 0));
        clear_inputs();
        step();

        // Retirement exactly DEPTH cycles after issue, still forwarding in that cycle.
        repeat (DEPTH) step();
        set_issue(0, 7'd3, 3'd1);
        push_wb(0, 7'd3);
        step();
        clear_inputs();
        repeat (5) step();
        #1 check("wb_early", wb_valid, '0);
        step();
        set_src(1, 0, 7'd3);
        #1;
        check("wb_valid_at_depth", wb_valid[0], 1'b1);
        check("wb_addr_at_depth", wb_addr[0 +: REG_AW], 7'd3);
        check("retire_fwd_hit", got_hit(1, 0), 1'b1);
        check("retire_fwd_data", got_data(1, 0), sd(0, 6));
        step();
        #1;
        check("post_retire_hit", got_hit(1, 0), 1'b0);
        check("post_retire_data", got_data(1, 0), rf(1, 0));
        clear_inputs();
        step();

        // Asynchronous reset with three entries in flight and a stalled bundle.
        set_issue(0, 7'd1, 3'd1);
        push_wb(0, 7'd1);
        step();
        clear_inputs();
        set_issue(0, 7'd2, 3'd7);
        push_wb(0, 7'd2);
        step();
        clear_inputs();
        set_issue(0, 7'd3, 3'd1);
        push_wb(0, 7'd3);
        step();
        clear_inputs();
        set_src(0, 0, 7'd1);
        set_src(1, 0, 7'd2);
        #1;
        check("pre_rst_stall", stall, 1'b1);
        check("pre_rst_hit", got_hit(0, 0), 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_stall", stall, 1'b0);
        check("async_rst_wb_valid", wb_valid, '0);
        check("async_rst_stall_count", stall_count, '0);
        check("async_rst_fwd_hit", src_fwd_hit, '0);
        wbq.delete();
        clear_inputs();
        step();
        rst_n = 1'b1;
        set_issue(0, 7'd4, 3'd1);
        set_src(1, 0, 7'd2);
        #1;
        check("post_rst_stall", stall, 1'b0);
        check("post_rst_hit", got_hit(1, 0), 1'b0);
        check("post_rst_data", got_data(1, 0), rf(1, 0));
        push_wb(0, 7'd4);
        step();
        clear_inputs();

        // Permanent intra-bundle hazard: the stall counter saturates.
        set_issue(0, 7'd9, 3'd1);
        set_src(1, 1, 7'd9);
        repeat (65535) step();
        check("sat_reach", stall_count, 16'hFFFF);
        repeat (4465) step();
        check("sat_hold", stall_count, 16'hFFFF);
        check("sat_stall", stall, 1'b1);
        clear_inputs();
        repeat (DEPTH + 1) step();
        check("wb_queue_drained", DATA_W'(wbq.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
